// File: rtl/store_alignment_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_alignment_unit_pkg
// Shared types and constants for the store alignment path.
//   memory_access_width_t : BYTE / HALF / WORD (WORD = 8 bytes)
//   store_state_t         : IDLE / BEAT0 / BEAT1 sequencing states
//   STRB_WIDTH            : byte strobes per write beat
//   width_bytes()         : number of bytes moved by an access width
// Also provides the `WORD_WIDTH / `WORD_MASK text macros.
// Optional feature macro used by the consuming RTL: STORE_SPLIT_EN.
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 64
`endif
`ifndef WORD_MASK
`define WORD_MASK 64'hFFFF_FFFF_FFFF_FFFF
`endif

package store_alignment_unit_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_access_width_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } store_state_t;

    localparam int STRB_WIDTH = 8;

    // Byte count of an access; the unused encoding is treated as a single byte.
    function automatic logic [3:0] width_bytes(input memory_access_width_t width);
        case (width)
            BYTE:    width_bytes = 4'd1;
            HALF:    width_bytes = 4'd2;
            WORD:    width_bytes = 4'd8;
            default: width_bytes = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
// Purely combinational lane placement for a store. The low bytes of the
// register value selected by the width are moved to their byte lanes across
// a two-beat (128-bit) window starting at the aligned beat address.
//   i_offset   : byte offset within the 8-byte beat (addr[2:0])
//   i_data     : register value; only the low 1/2/8 bytes are used
//   i_width    : access width
//   o_data     : 128-bit lane-aligned data, non-strobed bytes zero
//   o_strb     : 16-bit byte strobes over the same window
//   o_crossing : store touches the second beat
// -----------------------------------------------------------------------------
module store_lane_align
    import store_alignment_unit_pkg::*;
(
    input  logic [2:0]                   i_offset,
    input  logic [`WORD_WIDTH-1:0]       i_data,
    input  memory_access_width_t         i_width,
    output logic [2*`WORD_WIDTH-1:0]     o_data,
    output logic [2*STRB_WIDTH-1:0]      o_strb,
    output logic                         o_crossing
);

    logic [`WORD_WIDTH-1:0]   w_byte_mask;
    logic [2*`WORD_WIDTH-1:0] w_data_wide;
    logic [2*STRB_WIDTH-1:0]  w_strb_base;

    // Discard register bytes above the access width so garbage never reaches memory
    always_comb begin
        w_byte_mask = `WORD_MASK;
        case (i_width)
            BYTE:    w_byte_mask = 64'h0000_0000_0000_00FF;
            HALF:    w_byte_mask = 64'h0000_0000_0000_FFFF;
            default: w_byte_mask = `WORD_MASK;
        endcase
    end

    assign w_data_wide = {{`WORD_WIDTH{1'b0}}, i_data & w_byte_mask};
    assign o_data      = w_data_wide << {i_offset, 3'b000};

    assign w_strb_base = (16'd1 << width_bytes(i_width)) - 16'd1;
    assign o_strb      = w_strb_base << i_offset;

    assign o_crossing  = |o_strb[2*STRB_WIDTH-1:STRB_WIDTH];

endmodule

// File: rtl/store_alignment_unit.sv
// -----------------------------------------------------------------------------
// store_alignment_unit
// Turns a store request into 8-byte-aligned write beats with byte strobes.
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only when idle)
//   req_addr/data/width     : store byte address, register value, width
//   mem_valid/mem_ready     : write beat handshake
//   mem_addr/wdata/wstrb    : beat address (8-byte aligned), data, strobes
//   done                    : one-cycle pulse when the store is fully written
//   misaligned              : one-cycle pulse when a crossing store is dropped
// Feature macro STORE_SPLIT_EN: when defined, a store crossing an 8-byte
// boundary is written as two beats; when undefined it is accepted, no beat is
// issued, and misaligned pulses instead.
// -----------------------------------------------------------------------------
module store_alignment_unit
    import store_alignment_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [`WORD_WIDTH-1:0]   req_addr,
    input  logic [`WORD_WIDTH-1:0]   req_data,
    input  memory_access_width_t     req_width,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [`WORD_WIDTH-1:0]   mem_addr,
    output logic [`WORD_WIDTH-1:0]   mem_wdata,
    output logic [STRB_WIDTH-1:0]    mem_wstrb,
    output logic                     done,
    output logic                     misaligned
);

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT_ENABLED = 1'b1;
`else
    localparam bit SPLIT_ENABLED = 1'b0;
`endif

    store_state_t                 r_state;
    logic                         r_mem_valid;
    logic [`WORD_WIDTH-1:0]       r_mem_addr;
    logic [`WORD_WIDTH-1:0]       r_mem_wdata;
    logic [STRB_WIDTH-1:0]        r_mem_wstrb;
    logic [`WORD_WIDTH-1:0]       r_hi_wdata;
    logic [STRB_WIDTH-1:0]        r_hi_wstrb;
    logic                         r_done;
    logic                         r_misaligned;

    logic [2*`WORD_WIDTH-1:0]     w_lane_data;
    logic [2*STRB_WIDTH-1:0]      w_lane_strb;
    logic                         w_crossing;
    logic                         w_reject;
    logic                         w_split_next;

    store_lane_align u_lane_align (
        .i_offset   (req_addr[2:0]),
        .i_data     (req_data),
        .i_width    (req_width),
        .o_data     (w_lane_data),
        .o_strb     (w_lane_strb),
        .o_crossing (w_crossing)
    );

    // Without splitting, a crossing store is swallowed and reported instead
    assign w_reject     = w_crossing && !SPLIT_ENABLED;
    // The upper strobes captured at acceptance decide whether a second beat follows
    assign w_split_next = SPLIT_ENABLED && (r_hi_wstrb != '0);

    // Sequencer: beat registers are loaded at acceptance and held unchanged
    // while memory stalls; the second-beat payload waits in r_hi_* until beat 0
    // is taken. Returning to IDLE clears the beat fields and pulses done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_hi_wdata   <= '0;
            r_hi_wstrb   <= '0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_reject) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state     <= BEAT0;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {req_addr[`WORD_WIDTH-1:3], 3'b000};
                            r_mem_wdata <= w_lane_data[`WORD_WIDTH-1:0];
                            r_mem_wstrb <= w_lane_strb[STRB_WIDTH-1:0];
                            r_hi_wdata  <= w_lane_data[2*`WORD_WIDTH-1:`WORD_WIDTH];
                            r_hi_wstrb  <= w_lane_strb[2*STRB_WIDTH-1:STRB_WIDTH];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (w_split_next) begin
                            r_state     <= BEAT1;
                            r_mem_addr  <= r_mem_addr + 64'd8;
                            r_mem_wdata <= r_hi_wdata;
                            r_mem_wstrb <= r_hi_wstrb;
                        end else begin
                            r_state     <= IDLE;
                            r_mem_valid <= 1'b0;
                            r_mem_addr  <= '0;
                            r_mem_wdata <= '0;
                            r_mem_wstrb <= '0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        r_state     <= IDLE;
                        r_mem_valid <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_wstrb <= '0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;
    assign done       = r_done;
    assign misaligned = r_misaligned;

endmodule
